// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command reader.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    POP_CMD,
    HOLD_CMD,
    WAIT_ARG,
    POP_ARG,
    HOLD_ARG,
    EXEC,
    TX_WAIT,
    TX_HOLD
  } state_t;

  localparam logic [7:0] CMD_P = 8'h50;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_7  = 8'h37;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] ACK   = 8'h4B;
  localparam logic [7:0] NAK   = 8'h3F;

  // Clock-divider limit for speed digits '0'..'9'.
  function automatic logic [7:0] speed_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    speed_lut = 8'd1;
      4'd1:    speed_lut = 8'd2;
      4'd2:    speed_lut = 8'd3;
      4'd3:    speed_lut = 8'd5;
      4'd4:    speed_lut = 8'd8;
      4'd5:    speed_lut = 8'd12;
      4'd6:    speed_lut = 8'd20;
      4'd7:    speed_lut = 8'd35;
      4'd8:    speed_lut = 8'd60;
      4'd9:    speed_lut = 8'd100;
      default: speed_lut = 8'd1;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_hs.sv
// One-cycle strobe followed by a HOLDOFF-cycle quiet period (HOLDOFF >= 1).
module uart_byte_hs #(
  parameter int unsigned HOLDOFF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic fire,
  output logic strobe,
  output logic done_c
);

  localparam int unsigned CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Counter starts after the strobe cycle and counts the remaining quiet cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe <= 1'b0;
      cnt_q  <= '0;
    end else begin
      strobe <= fire;
      if (fire) begin
        cnt_q <= CNT_W'(HOLDOFF - 1);
      end else if (!strobe && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign done_c = !strobe && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_rx.sv
// Parses two-byte ASCII commands from the UART and answers each with ACK/NAK.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int unsigned HOLDOFF     = 2,
  parameter int unsigned ARG_TIMEOUT = 200,
  parameter int unsigned DEF_PAT     = 0,
  parameter int unsigned DEF_LIM     = 2
) (
  input  logic       hz100,
  input  logic       reset,
  input  logic [7:0] rxdata,
  input  logic       rxready,
  output logic       rxclk,
  output logic [7:0] txdata,
  input  logic       txready,
  output logic       txclk,
  output logic [2:0] pat_sel,
  output logic [7:0] div_lim,
  output logic       cfg_update,
  output logic       cmd_err
);

  localparam int unsigned TMO_W = $clog2(ARG_TIMEOUT);

  state_t           state, next_state;
  logic [7:0]       cmd_q, arg_q, resp_q;
  logic [TMO_W-1:0] tmo_q;

  logic       rx_fire, tx_fire, rx_done_c, tx_done_c;
  logic       tmo_clr, resp_load, pat_load, lim_load, cfg_rst;
  logic [7:0] resp_d, lim_d;
  logic [2:0] pat_d;

  uart_byte_hs #(.HOLDOFF(HOLDOFF)) u_rx_hs (
    .clk    (hz100),
    .reset  (reset),
    .fire   (rx_fire),
    .strobe (rxclk),
    .done_c (rx_done_c)
  );

  uart_byte_hs #(.HOLDOFF(HOLDOFF)) u_tx_hs (
    .clk    (hz100),
    .reset  (reset),
    .fire   (tx_fire),
    .strobe (txclk),
    .done_c (tx_done_c)
  );

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    rx_fire    = 1'b0;
    tx_fire    = 1'b0;
    tmo_clr    = 1'b0;
    resp_load  = 1'b0;
    resp_d     = NAK;
    pat_load   = 1'b0;
    pat_d      = pat_sel;
    lim_load   = 1'b0;
    lim_d      = div_lim;
    cfg_rst    = 1'b0;
    case (state)
      IDLE: begin
        if (rxready) begin
          rx_fire    = 1'b1;
          next_state = POP_CMD;
        end
      end
      POP_CMD: next_state = HOLD_CMD;
      HOLD_CMD: begin
        if (rx_done_c) begin
          if (cmd_q == CH_CR || cmd_q == CH_LF) begin
            next_state = IDLE;
          end else if (cmd_q == CMD_P || cmd_q == CMD_S) begin
            tmo_clr    = 1'b1;
            next_state = WAIT_ARG;
          end else if (cmd_q == CMD_R) begin
            next_state = EXEC;
          end else begin
            resp_load  = 1'b1;
            next_state = TX_WAIT;
          end
        end
      end
      // Timeout leaves any late argument byte queued upstream.
      WAIT_ARG: begin
        if (rxready) begin
          rx_fire    = 1'b1;
          next_state = POP_ARG;
        end else if (tmo_q == TMO_W'(ARG_TIMEOUT - 1)) begin
          resp_load  = 1'b1;
          next_state = TX_WAIT;
        end
      end
      POP_ARG: next_state = HOLD_ARG;
      HOLD_ARG: begin
        if (rx_done_c) next_state = EXEC;
      end
      EXEC: begin
        resp_load  = 1'b1;
        next_state = TX_WAIT;
        if (cmd_q == CMD_R) begin
          cfg_rst = 1'b1;
          resp_d  = ACK;
        end else if (cmd_q == CMD_P && arg_q >= CH_0 && arg_q <= CH_7) begin
          pat_load = 1'b1;
          pat_d    = arg_q[2:0];
          resp_d   = ACK;
        end else if (cmd_q == CMD_S && arg_q >= CH_0 && arg_q <= CH_9) begin
          lim_load = 1'b1;
          lim_d    = speed_lut(4'(arg_q - CH_0));
          resp_d   = ACK;
        end
      end
      TX_WAIT: begin
        if (txready) begin
          tx_fire    = 1'b1;
          next_state = TX_HOLD;
        end
      end
      TX_HOLD: begin
        if (tx_done_c) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      cmd_q      <= 8'h00;
      arg_q      <= 8'h00;
      resp_q     <= 8'h00;
      tmo_q      <= '0;
      txdata     <= 8'h00;
      pat_sel    <= 3'(DEF_PAT);
      div_lim    <= 8'(DEF_LIM);
      cfg_update <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      if (rx_fire && state == IDLE)     cmd_q <= rxdata;
      if (rx_fire && state == WAIT_ARG) arg_q <= rxdata;
      if (resp_load) resp_q <= resp_d;
      if (tmo_clr)                tmo_q <= '0;
      else if (state == WAIT_ARG) tmo_q <= tmo_q + TMO_W'(1);
      if (tx_fire) txdata <= resp_q;
      if (pat_load) pat_sel <= pat_d;
      if (lim_load) div_lim <= lim_d;
      if (cfg_rst) begin
        pat_sel <= 3'(DEF_PAT);
        div_lim <= 8'(DEF_LIM);
      end
      cfg_update <= pat_load | lim_load | cfg_rst;
      if (tx_fire && resp_q == NAK) cmd_err <= 1'b1;
      else if (cfg_rst)             cmd_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx with a byte-queue model of the upstream UART.
module tb_uart_cmd_rx;

  logic       hz100 = 1'b0;
  logic       reset;
  logic [7:0] rxdata;
  logic       rxready;
  logic       rxclk;
  logic [7:0] txdata;
  logic       txready;
  logic       txclk;
  logic [2:0] pat_sel;
  logic [7:0] div_lim;
  logic       cfg_update;
  logic       cmd_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rx_cnt = 0, tx_cnt = 0, cfg_cnt = 0, hs_viol = 0;
  int rx_first_cyc = 0, rx_last_cyc = 0, tx_last_cyc = 0;
  bit prev_strobe = 1'b0;
  logic [7:0] rx_q[$];

  uart_cmd_rx dut (
    .hz100      (hz100),
    .reset      (reset),
    .rxdata     (rxdata),
    .rxready    (rxready),
    .rxclk      (rxclk),
    .txdata     (txdata),
    .txready    (txready),
    .txclk      (txclk),
    .pat_sel    (pat_sel),
    .div_lim    (div_lim),
    .cfg_update (cfg_update),
    .cmd_err    (cmd_err)
  );

  always #5 hz100 = ~hz100;

  always @(posedge hz100) cyc <= cyc + 1;

  // Upstream queue model plus strobe monitor, evaluated mid-cycle.
  always @(negedge hz100) begin
    if (rxclk) begin
      rx_cnt = rx_cnt + 1;
      if (rx_cnt == 1) rx_first_cyc = cyc;
      rx_last_cyc = cyc;
      if (rx_q.size() != 0) void'(rx_q.pop_front());
    end
    if (txclk) begin
      tx_cnt = tx_cnt + 1;
      tx_last_cyc = cyc;
    end
    if (cfg_update) cfg_cnt = cfg_cnt + 1;
    if (rxclk && txclk) hs_viol = hs_viol + 1;
    if ((rxclk || txclk) && prev_strobe) hs_viol = hs_viol + 1;
    prev_strobe = rxclk | txclk;
    rxready = (rx_q.size() != 0);
    rxdata  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  task automatic step();
    @(negedge hz100);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    rx_cnt = 0;
    tx_cnt = 0;
    cfg_cnt = 0;
  endtask

  task automatic wait_tx(input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      step();
      if (tx_cnt != 0) ok = 1'b1;
      n++;
    end
  endtask

  task automatic wait_rx(input int target, input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      step();
      if (rx_cnt >= target) ok = 1'b1;
      n++;
    end
  endtask

  // Push a command, wait for its response and let the FSM settle in IDLE.
  task automatic run_cmd(input logic [7:0] b0, input logic [7:0] b1, input bit two, input string name);
    bit ok;
    clear_counts();
    rx_q.push_back(b0);
    if (two) rx_q.push_back(b1);
    wait_tx(60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s_tx_timeout got=none exp=txclk", name); end
    idle(6);
  endtask

  task automatic test_reset();
    reset = 1'b1; rxready = 1'b0; rxdata = 8'h00; txready = 1'b1;
    idle(3);
    checks++; if (rxclk !== 1'b0)      begin failures++; $display("FAIL rst_rxclk got=%b exp=0", rxclk); end
    checks++; if (txclk !== 1'b0)      begin failures++; $display("FAIL rst_txclk got=%b exp=0", txclk); end
    checks++; if (txdata !== 8'h00)    begin failures++; $display("FAIL rst_txdata got=%h exp=00", txdata); end
    checks++; if (pat_sel !== 3'd0)    begin failures++; $display("FAIL rst_pat got=%0d exp=0", pat_sel); end
    checks++; if (div_lim !== 8'd2)    begin failures++; $display("FAIL rst_lim got=%0d exp=2", div_lim); end
    checks++; if (cfg_update !== 1'b0) begin failures++; $display("FAIL rst_cfg got=%b exp=0", cfg_update); end
    checks++; if (cmd_err !== 1'b0)    begin failures++; $display("FAIL rst_err got=%b exp=0", cmd_err); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_pattern();
    run_cmd(8'h50, 8'h35, 1'b1, "p5");
    checks++; if (rx_cnt !== 2)      begin failures++; $display("FAIL p5_rxclk got=%0d exp=2", rx_cnt); end
    checks++; if (pat_sel !== 3'd5)  begin failures++; $display("FAIL p5_pat got=%0d exp=5", pat_sel); end
    checks++; if (cfg_cnt !== 1)     begin failures++; $display("FAIL p5_cfg got=%0d exp=1", cfg_cnt); end
    checks++; if (txdata !== 8'h4B)  begin failures++; $display("FAIL p5_txdata got=%h exp=4b", txdata); end
    checks++; if (tx_cnt !== 1)      begin failures++; $display("FAIL p5_txclk got=%0d exp=1", tx_cnt); end
    checks++; if (cmd_err !== 1'b0)  begin failures++; $display("FAIL p5_err got=%b exp=0", cmd_err); end
    checks++; if (tx_last_cyc - rx_first_cyc !== 9)
      begin failures++; $display("FAIL p5_latency got=%0d exp=9", tx_last_cyc - rx_first_cyc); end
  endtask

  task automatic test_speed_reset();
    run_cmd(8'h53, 8'h39, 1'b1, "s9");
    checks++; if (div_lim !== 8'd100) begin failures++; $display("FAIL s9_lim got=%0d exp=100", div_lim); end
    checks++; if (txdata !== 8'h4B)   begin failures++; $display("FAIL s9_txdata got=%h exp=4b", txdata); end
    run_cmd(8'h53, 8'h41, 1'b1, "sa");
    checks++; if (div_lim !== 8'd100) begin failures++; $display("FAIL sa_lim got=%0d exp=100", div_lim); end
    checks++; if (txdata !== 8'h3F)   begin failures++; $display("FAIL sa_txdata got=%h exp=3f", txdata); end
    checks++; if (cmd_err !== 1'b1)   begin failures++; $display("FAIL sa_err got=%b exp=1", cmd_err); end
    checks++; if (cfg_cnt !== 0)      begin failures++; $display("FAIL sa_cfg got=%0d exp=0", cfg_cnt); end
    run_cmd(8'h52, 8'h00, 1'b0, "r");
    checks++; if (rx_cnt !== 1)       begin failures++; $display("FAIL r_rxclk got=%0d exp=1", rx_cnt); end
    checks++; if (pat_sel !== 3'd0)   begin failures++; $display("FAIL r_pat got=%0d exp=0", pat_sel); end
    checks++; if (div_lim !== 8'd2)   begin failures++; $display("FAIL r_lim got=%0d exp=2", div_lim); end
    checks++; if (cmd_err !== 1'b0)   begin failures++; $display("FAIL r_err got=%b exp=0", cmd_err); end
    checks++; if (txdata !== 8'h4B)   begin failures++; $display("FAIL r_txdata got=%h exp=4b", txdata); end
    checks++; if (cfg_cnt !== 1)      begin failures++; $display("FAIL r_cfg got=%0d exp=1", cfg_cnt); end
  endtask

  task automatic test_bad_and_eol();
    run_cmd(8'h50, 8'h36, 1'b1, "p6");
    checks++; if (pat_sel !== 3'd6)   begin failures++; $display("FAIL p6_pat got=%0d exp=6", pat_sel); end
    run_cmd(8'h58, 8'h00, 1'b0, "x");
    checks++; if (rx_cnt !== 1)       begin failures++; $display("FAIL x_rxclk got=%0d exp=1", rx_cnt); end
    checks++; if (txdata !== 8'h3F)   begin failures++; $display("FAIL x_txdata got=%h exp=3f", txdata); end
    checks++; if (pat_sel !== 3'd6)   begin failures++; $display("FAIL x_pat got=%0d exp=6", pat_sel); end
    checks++; if (div_lim !== 8'd2)   begin failures++; $display("FAIL x_lim got=%0d exp=2", div_lim); end
    checks++; if (cmd_err !== 1'b1)   begin failures++; $display("FAIL x_err got=%b exp=1", cmd_err); end
    clear_counts();
    rx_q.push_back(8'h0D);
    idle(30);
    checks++; if (rx_cnt !== 1)       begin failures++; $display("FAIL cr_rxclk got=%0d exp=1", rx_cnt); end
    checks++; if (tx_cnt !== 0)       begin failures++; $display("FAIL cr_txclk got=%0d exp=0", tx_cnt); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_counts();
    rx_q.push_back(8'h50);
    idle(150);
    checks++; if (tx_cnt !== 0)       begin failures++; $display("FAIL tmo_early got=%0d exp=0", tx_cnt); end
    wait_tx(200, ok);
    checks++; if (!ok)                begin failures++; $display("FAIL tmo_tx_timeout got=none exp=txclk"); end
    checks++; if (txdata !== 8'h3F)   begin failures++; $display("FAIL tmo_txdata got=%h exp=3f", txdata); end
    checks++; if (tx_last_cyc - rx_first_cyc !== 204)
      begin failures++; $display("FAIL tmo_latency got=%0d exp=204", tx_last_cyc - rx_first_cyc); end
    idle(6);
    run_cmd(8'h33, 8'h00, 1'b0, "late3");
    checks++; if (rx_cnt !== 1)       begin failures++; $display("FAIL late3_rxclk got=%0d exp=1", rx_cnt); end
    checks++; if (txdata !== 8'h3F)   begin failures++; $display("FAIL late3_txdata got=%h exp=3f", txdata); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int raise_cyc;
    clear_counts();
    txready = 1'b0;
    rx_q.push_back(8'h50);
    rx_q.push_back(8'h31);
    rx_q.push_back(8'h53);
    idle(50);
    checks++; if (rx_cnt !== 2)       begin failures++; $display("FAIL bp_rxclk got=%0d exp=2", rx_cnt); end
    checks++; if (tx_cnt !== 0)       begin failures++; $display("FAIL bp_txclk got=%0d exp=0", tx_cnt); end
    checks++; if (pat_sel !== 3'd1)   begin failures++; $display("FAIL bp_pat got=%0d exp=1", pat_sel); end
    raise_cyc = cyc;
    txready = 1'b1;
    wait_tx(10, ok);
    checks++; if (!ok || tx_last_cyc !== raise_cyc + 1)
      begin failures++; $display("FAIL bp_ack_cycle got=%0d exp=%0d", tx_last_cyc - raise_cyc, 1); end
    checks++; if (txdata !== 8'h4B)   begin failures++; $display("FAIL bp_txdata got=%h exp=4b", txdata); end
    wait_rx(3, 20, ok);
    checks++; if (!ok || rx_last_cyc !== tx_last_cyc + 4)
      begin failures++; $display("FAIL bp_next_pop got=%0d exp=%0d", rx_last_cyc - tx_last_cyc, 4); end
    clear_counts();
    rx_q.push_back(8'h32);
    wait_tx(40, ok);
    idle(6);
    checks++; if (!ok || txdata !== 8'h4B) begin failures++; $display("FAIL s2_txdata got=%h exp=4b", txdata); end
    checks++; if (div_lim !== 8'd3)   begin failures++; $display("FAIL s2_lim got=%0d exp=3", div_lim); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_counts();
    rx_q.push_back(8'h50);
    wait_rx(1, 20, ok);
    idle(4);
    #2 reset = 1'b1;
    rx_q.delete();
    rxready = 1'b0;
    #1;
    checks++; if (!ok || pat_sel !== 3'd0) begin failures++; $display("FAIL mid_pat got=%0d exp=0", pat_sel); end
    checks++; if (div_lim !== 8'd2)   begin failures++; $display("FAIL mid_lim got=%0d exp=2", div_lim); end
    checks++; if (txdata !== 8'h00)   begin failures++; $display("FAIL mid_txdata got=%h exp=00", txdata); end
    checks++; if (rxclk !== 1'b0 || txclk !== 1'b0)
      begin failures++; $display("FAIL mid_strobes got=%b%b exp=00", rxclk, txclk); end
    step();
    reset = 1'b0;
    idle(30);
    checks++; if (tx_cnt !== 0)       begin failures++; $display("FAIL mid_txclk got=%0d exp=0", tx_cnt); end
    run_cmd(8'h50, 8'h37, 1'b1, "p7");
    checks++; if (pat_sel !== 3'd7)   begin failures++; $display("FAIL p7_pat got=%0d exp=7", pat_sel); end
    checks++; if (txdata !== 8'h4B)   begin failures++; $display("FAIL p7_txdata got=%h exp=4b", txdata); end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_speed_reset();
    test_bad_and_eol();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    checks++; if (hs_viol !== 0) begin failures++; $display("FAIL strobe_spacing got=%0d exp=0", hs_viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Command reader for the board's byte-wide UART port. It consumes bytes via the rxdata/rxready/rxclk handshake and parses two-byte ASCII commands.
- Drives the idle-animation pattern select and the clock-divider limit.
- Answers every parsed command with one ACK/NAK byte via txdata/txready/txclk.
- Sits in top between the UART pins and the pattern mux / clkdiv lim input.

Parameters:
- HOLDOFF, 2, idle cycles after any rxclk/txclk pulse before rxready/txready is sampled again
- ARG_TIMEOUT, 200, cycles to wait for a command's argument byte before NAK (200 = 2 s at 100 Hz)
- DEF_PAT, 0, pat_sel value at reset and on 'R'
- DEF_LIM, 2, div_lim value at reset and on 'R'

Ports:
- hz100  input  1  system clock
- reset  input  1  asynchronous active-high reset
- rxdata  input  8  received byte, valid while rxready=1
- rxready  input  1  level: a byte is available
- rxclk  output  1  one-cycle pop strobe for rxdata
- txdata  output  8  response byte, held stable from txclk pulse until next load
- txready  input  1  level: transmitter can accept a byte
- txclk  output  1  one-cycle load strobe for txdata
- pat_sel  output  3  selected animation pattern
- div_lim  output  8  clkdiv limit
- cfg_update  output  1  one-cycle pulse when pat_sel or div_lim is written
- cmd_err  output  1  sticky; set on any NAK, cleared by reset or 'R'

Behaviour:
- One clock (hz100); reset is asynchronous and active-high.
- Reset values: rxclk=0, txclk=0, txdata=0x00, pat_sel=DEF_PAT, div_lim=DEF_LIM, cfg_update=0, cmd_err=0, state=IDLE, counters=0.
- FSM states: IDLE, POP_CMD, HOLD_CMD, WAIT_ARG, POP_ARG, HOLD_ARG, EXEC, TX_WAIT, TX_HOLD.
- IDLE: when rxready=1, latch rxdata into cmd_reg and go to POP_CMD.
- POP_CMD: rxclk=1 for exactly this cycle. Then HOLD_CMD for HOLDOFF cycles, rxclk=0.
- HOLD_CMD exit, by cmd_reg:
  - 0x0D or 0x0A: back to IDLE, no response.
  - 'P' (0x50) or 'S' (0x53): WAIT_ARG, timeout counter cleared.
  - 'R' (0x52): EXEC.
  - Any other byte: resp=NAK, go to TX_WAIT.
- WAIT_ARG:
  - rxready=1: latch the argument and go to POP_ARG, then HOLD_ARG (HOLDOFF cycles), then EXEC.
  - Counter reaches ARG_TIMEOUT-1 with rxready still 0: resp=NAK, go to TX_WAIT. The argument is not consumed.
- EXEC, one cycle:
  - 'P' with arg '0'..'7' (0x30–0x37): pat_sel<=arg[2:0], cfg_update=1, resp=ACK.
  - 'S' with arg '0'..'9': div_lim<=SPEED_LUT[arg-0x30], cfg_update=1, resp=ACK.
  - 'R': pat_sel<=DEF_PAT, div_lim<=DEF_LIM, cmd_err<=0, cfg_update=1, resp=ACK.
  - Any out-of-range argument: outputs unchanged, resp=NAK.
  - Then go to TX_WAIT.
- TX_WAIT: when txready=1, txdata<=resp and txclk=1 for one cycle. Then TX_HOLD for HOLDOFF cycles, then IDLE.
- Response bytes: ACK=0x4B 'K', NAK=0x3F '?'. cmd_err is set in the cycle a NAK is loaded.
- Backpressure: no rxclk is issued in TX_WAIT/TX_HOLD. Input bytes stay queued upstream and none are dropped.
- rxclk and txclk are never asserted in the same cycle, and never on consecutive cycles.
- Exactly one response per non-CR/LF first byte. No parsing pipelining; next command starts only from IDLE.
- Asynchronous reset mid-command: the partial command is discarded, outputs return to reset values, and no response is sent.
- Minimum full-command latency (first byte seen to txclk, txready=1): 1 + 1 + HOLDOFF + 1 + 1 + HOLDOFF + 1 cycles = 9 at HOLDOFF=2.

Decomposition:
- Shared package uart_cmd_pkg:
  - state enum
  - ASCII constants: CMD_P, CMD_S, CMD_R, CH_CR, CH_LF, ACK, NAK
  - SPEED_LUT (10×8-bit: 1,2,3,5,8,12,20,35,60,100)
- One sub-module: uart_byte_hs. It handles the generic ready/strobe/holdoff sequencing and is instantiated twice, once for rx pop and once for tx load.

Test Plan:
- Bytes 'P','5' with rxready asserted, txready=1 -> rxclk pulses twice; pat_sel=5; one cfg_update pulse; txdata=0x4B with single txclk; cmd_err=0.
- 'S','9' -> div_lim=100, ACK. Then 'S','A' -> div_lim stays 100, txdata=0x3F, cmd_err=1. Then 'R' -> pat_sel=0, div_lim=2, cmd_err=0, ACK.
- Byte 'X' -> one rxclk, NAK returned, pat_sel/div_lim unchanged. Byte 0x0D -> one rxclk, no txclk.
- 'P' then no data for 200 cycles -> NAK at timeout. A later '3' is treated as a new command and NAKed.
- 'P','1' with txready=0 for 50 cycles while the next byte 'S' is pending -> no rxclk until after txclk. ACK issues the cycle after txready rises.
- reset asserted between 'P' pop and argument -> all outputs return to reset values immediately. No txclk; the next command parses normally.
